vga_timing_gen: RTL and testbench

Display timing generator and pixel output stage for the VGA path. It drives the `display_next_frame`, `display_next_line`, `display_next_pixel` and `display_current_field` strobes that pace the composer. It takes the composer's `display_data` palette index back, looks it up in the external palette RAM, and drives the VGA pins with sync and blanking aligned to the pixel pipeline. One pixel is produced per `clk` cycle, with `clk` at 25 MHz.

---
 rtl/vga_timing_gen_if.sv | 33 +++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Composer, palette RAM and VGA pin bundle for the display timing generator.
// The generator owns the strobes, palette address and pins; its peer owns data and palette read data.
interface vga_timing_gen_if;
    logic        display_next_frame;
    logic        display_next_line;
    logic        display_next_pixel;
    logic        display_current_field;
    logic [7:0]  display_data;
    logic [7:0]  palette_addr;
    logic [11:0] palette_rgb;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank;

    modport master (
        output display_next_frame, display_next_line, display_next_pixel, display_current_field,
        input  display_data,
        output palette_addr,
        input  palette_rgb,
        output vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank
    );

    modport slave (
        input  display_next_frame, display_next_line, display_next_pixel, display_current_field,
        output display_data,
        input  palette_addr,
        output palette_rgb,
        input  vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator: h/v counters, composer strobes, field tracking and a 4-stage
// pixel pipeline (data -> palette address -> palette data -> pins) with aligned sync/blank.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             interlaced,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic       enable_r;
    logic [9:0] h;
    logic [9:0] v;
    logic       field;
    logic       line_end;
    logic       frame_end;
    logic       hs0;
    logic       vs0;
    logic       act0;
    logic [2:0] hs_sr;
    logic [2:0] vs_sr;
    logic [2:0] act_sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable_r <= 1'b0;
        end else begin
            enable_r <= enable;
        end
    end

    // Counters sit at (0,0) whenever the registered enable is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (!enable_r) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end else begin
            h <= h + 10'd1;
        end
    end

    assign line_end  = enable_r && (h == H_LAST);
    assign frame_end = line_end && (v == V_LAST);

    assign bus.display_next_pixel    = enable_r && (h < H_ACT);
    assign bus.display_next_line     = line_end;
    assign bus.display_next_frame    = frame_end;
    assign bus.display_current_field = field;

    // The field flips only after the frame's last pixel, so the ending field is still shown on it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            field <= 1'b0;
        end else if (frame_end) begin
            field <= interlaced & ~field;
        end
    end

    assign hs0  = (h >= HS_START) && (h < HS_END);
    assign vs0  = (v >= VS_START) && (v < VS_END);
    assign act0 = enable_r && (h < H_ACT) && (v < V_ACT);

    // Three delay stages here plus the pin registers give the 4-clock pin latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_sr  <= '0;
            vs_sr  <= '0;
            act_sr <= '0;
        end else begin
            hs_sr  <= {hs_sr[1:0], hs0};
            vs_sr  <= {vs_sr[1:0], vs0};
            act_sr <= {act_sr[1:0], act0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.palette_addr <= '0;
        end else begin
            bus.palette_addr <= bus.display_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.vga_r     <= '0;
            bus.vga_g     <= '0;
            bus.vga_b     <= '0;
            bus.vga_blank <= 1'b1;
            bus.vga_hsync <= ~HSYNC_POL;
            bus.vga_vsync <= ~VSYNC_POL;
        end else begin
            bus.vga_r     <= act_sr[2] ? bus.palette_rgb[11:8] : 4'h0;
            bus.vga_g     <= act_sr[2] ? bus.palette_rgb[7:4]  : 4'h0;
            bus.vga_b     <= act_sr[2] ? bus.palette_rgb[3:0]  : 4'h0;
            bus.vga_blank <= ~act_sr[2];
            bus.vga_hsync <= hs_sr[2] ? HSYNC_POL : ~HSYNC_POL;
            bus.vga_vsync <= vs_sr[2] ? VSYNC_POL : ~VSYNC_POL;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster, palette RAM model, and a position-based reference
// model (frame position -> h,v) checked every cycle, plus reset, enable-drop and field scenarios.
module tb_vga_timing_gen;
    localparam int HA = 40, HF = 6, HS = 8, HB = 6;
    localparam int VA = 10, VF = 2, VS = 3, VB = 4;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit HSP = 1'b0;
    localparam bit VSP = 1'b1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b1;
    logic interlaced = 1'b0;

    vga_timing_gen_if bus();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .HSYNC_POL(HSP), .VSYNC_POL(VSP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .interlaced(interlaced),
        .bus(bus)
    );

    always #20 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_line = -1;
    int last_frame = -1;

    bit            m_en_r;
    int            m_p;
    bit            m_field;
    logic [14:0]   pin_q[$];
    logic [7:0]    dd_next;
    logic [11:0]   rgb_next;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [11:0] pal(input logic [7:0] idx);
        return {idx[3:0], idx[7:4], idx[3:0]};
    endfunction

    function automatic logic [14:0] pin_rec(input bit en_r, input int h, input int v);
        logic [7:0] hb;
        bit act, hs, vs;
        hb  = 8'(h);
        act = en_r && (h < HA) && (v < VA);
        hs  = (h >= HA + HF) && (h < HA + HF + HS);
        vs  = (v >= VA + VF) && (v < VA + VF + VS);
        return {~act, hs ? HSP : ~HSP, vs ? VSP : ~VSP, act ? pal(hb) : 12'h000};
    endfunction

    function automatic logic [14:0] obs_pins();
        return {bus.vga_blank, bus.vga_hsync, bus.vga_vsync, bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    function automatic logic [3:0] obs_strobes();
        return {bus.display_next_frame, bus.display_next_line, bus.display_next_pixel,
                bus.display_current_field};
    endfunction

    task automatic model_reset();
        m_en_r  = 1'b0;
        m_p     = 0;
        m_field = 1'b0;
        pin_q.delete();
        repeat (4) pin_q.push_back(pin_rec(1'b0, 0, 0));
        last_line  = -1;
        last_frame = -1;
    endtask

    // Called at a falling edge: check this cycle, advance the model, drive stage-1 data and RAM data.
    task automatic step();
        int mh, mv;
        bit e_pix, e_line, e_frame;
        mh      = m_p % HT;
        mv      = (m_p / HT) % VT;
        e_pix   = m_en_r && (mh < HA);
        e_line  = m_en_r && (mh == HT - 1);
        e_frame = e_line && (mv == VT - 1);
        check("strobes", obs_strobes(), {e_frame, e_line, e_pix, m_field});
        check("pins", obs_pins(), pin_q.pop_front());
        pin_q.push_back(pin_rec(m_en_r, mh, mv));
        if (bus.display_next_line) begin
            if (last_line >= 0) check("line_period", cyc - last_line, HT);
            last_line = cyc;
        end
        if (bus.display_next_frame) begin
            if (last_frame >= 0) check("frame_period", cyc - last_frame, HT * VT);
            last_frame = cyc;
        end
        rgb_next = pal(bus.palette_addr);
        dd_next  = e_pix ? 8'(mh) : 8'h55;
        if (e_frame) m_field = interlaced & ~m_field;
        m_p    = m_en_r ? (m_p + 1) % (HT * VT) : 0;
        m_en_r = enable;
        @(posedge clk);
        #1;
        bus.display_data = dd_next;
        bus.palette_rgb  = rgb_next;
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_strobes"}, obs_strobes(), 4'b0000);
        check({tag, "_pins"}, obs_pins(), {1'b1, ~HSP, ~VSP, 12'h000});
        check({tag, "_addr"}, bus.palette_addr, 8'h00);
    endtask

    // Entered at a falling edge with enable high; reset asserts mid-cycle.
    task automatic do_reset();
        int k;
        bit seen;
        rst = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.display_data = 8'h55;
        bus.palette_rgb  = 12'h000;
        @(negedge clk);
        k = 0;
        for (int i = 1; i <= 5; i++) begin
            seen = bus.display_next_pixel;
            step();
            if (seen && k == 0) k = i;
        end
        check("first_pix_after_rst", k, 2);
    endtask

    task automatic drop_enable(input int hold);
        enable = 1'b0;
        step();
        check("pix_stop", bus.display_next_pixel, 1'b0);
        repeat (hold - 1) step();
        last_line  = -1;
        last_frame = -1;
        enable = 1'b1;
        step();
        check("pix_after_reenable", bus.display_next_pixel, 1'b1);
    endtask

    task automatic run_to_frame_end();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * HT * VT && !found; i++) begin
            found = bus.display_next_frame;
            step();
        end
        if (!found) check("frame_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        logic [3:0] field_exp;
        int tgt;
        field_exp = 4'b0101;
        bus.display_data = 8'h55;
        bus.palette_rgb  = 12'h000;
        interlaced = 1'b1;
        model_reset();
        @(negedge clk);
        check_reset_values("init_rst");
        enable = 1'b1;
        do_reset();

        // Field sequence: three interlaced frames, then one progressive frame.
        for (int f = 0; f < 4; f++) begin
            interlaced = (f < 3);
            run_to_frame_end();
            check("field_after_frame", bus.display_current_field, field_exp[f]);
        end

        // Enable drop in mid-line.
        for (int i = 0; i < 2 * HT && (m_p % HT) != 30; i++) step();
        drop_enable(10);

        // Async reset at a random raster position.
        tgt = $urandom_range(HT * 3, HT * VT - 1);
        for (int i = 0; i < tgt; i++) step();
        do_reset();

        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 999) == 0) drop_enable($urandom_range(2, 12));
            else if ($urandom_range(0, 3999) == 0) do_reset();
            if ($urandom_range(0, 1499) == 0) interlaced = ~interlaced;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
